// File: rtl/divu_pkg.sv
// Shared types and constants for the iterative unsigned divider.
package divu_pkg;
  localparam int DIVU_W     = 32;
  localparam int DIVU_CNT_W = $clog2(DIVU_W + 1);

  typedef enum logic [1:0] {DIVU_IDLE, DIVU_BUSY, DIVU_DONE} divu_state_t;
endpackage

// File: rtl/divu_if.sv
// Start/busy/done handshake and operand/result bus of the iterative divider.
interface divu_if
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_W
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (output start, a, b, input q, r, busy, done, dz);
  modport slave  (input start, a, b, output q, r, busy, done, dz);
endinterface

// File: rtl/divu_step.sv
// One combinational restoring shift-subtract step of the unsigned divider.
module divu_step
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // The compare keeps the bit shifted out of rem; the low WIDTH bits of the
  // difference are exact because the true result is always below the divisor.
  assign w_shift  = {rem, quo[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, divisor});
  assign w_diff   = w_shift[WIDTH-1:0] - divisor;
  assign rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/divu_iter.sv
// Multi-cycle unsigned divider, one quotient bit per clock.
// Optional DIVU_ZERO_FAST_EN: a zero divisor finishes in one edge without entering BUSY.
module divu_iter
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_W
) (
  input  logic   clk,
  input  logic   reset,
  divu_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  divu_state_t      r_state;
  divu_state_t      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_accept;
  logic             w_step;
  logic             w_finish;
`ifdef DIVU_ZERO_FAST_EN
  logic             w_fast;
`endif

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .divisor  (r_div),
    .rem_next (w_rem_next),
    .quo_next (w_quo_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
`ifdef DIVU_ZERO_FAST_EN
    w_fast       = 1'b0;
`endif
    bus.busy     = (r_state == DIVU_BUSY);
    bus.done     = (r_state == DIVU_DONE);
    case (r_state)
      DIVU_BUSY: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = DIVU_DONE;
          w_finish     = 1'b1;
        end
      end
      DIVU_DONE: w_state_next = DIVU_IDLE;
      default:   w_state_next = DIVU_IDLE;
    endcase
    // DONE accepts a new start directly so back-to-back divides lose no cycle.
    if ((r_state != DIVU_BUSY) && bus.start) begin
      w_accept     = 1'b1;
      w_state_next = DIVU_BUSY;
`ifdef DIVU_ZERO_FAST_EN
      if (bus.b == '0) begin
        w_fast       = 1'b1;
        w_state_next = DIVU_DONE;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DIVU_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rem <= '0;
        r_quo <= bus.a;
        r_div <= bus.b;
        r_cnt <= CNT_W'(WIDTH);
      end else if (w_step) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_finish) begin
        r_q  <= w_quo_next;
        r_r  <= w_rem_next;
        r_dz <= (r_div == '0);
      end
`ifdef DIVU_ZERO_FAST_EN
      if (w_fast) begin
        r_q  <= '1;
        r_r  <= bus.a;
        r_dz <= 1'b1;
      end
`endif
    end
  end

  assign bus.q  = r_q;
  assign bus.r  = r_r;
  assign bus.dz = r_dz;
endmodule

// File: tb/tb_divu_iter.sv
// Scoreboard bench for divu_iter: directed vectors plus a short random sweep.
module tb_divu_iter;
  import divu_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    string       name;
  } exp_t;

  logic  clk;
  logic  reset;
  exp_t  sb[$];
  int    n_cmp;
  int    n_bad;
  int    n_done;
  int    lat_cnt;
  int    busy_cyc;

  divu_if bus ();

  divu_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (bus.busy) busy_cyc++;
    @(posedge clk);
    #1;
    lat_cnt++;
  endtask

  // Results are checked by the monitor whenever done is seen.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.done) begin
      n_done++;
      n_cmp++;
      if (bus.busy) begin
        n_bad++;
        $display("FAIL busy_with_done busy=%b done=%b expected busy=0", bus.busy, bus.done);
      end
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done q=%0h r=%0h dz=%b with empty scoreboard", bus.q, bus.r, bus.dz);
      end else begin
        e = sb.pop_front();
        if (bus.q !== e.q || bus.r !== e.r || bus.dz !== e.dz) begin
          n_bad++;
          $display("FAIL %s q=%0h r=%0h dz=%b expected q=%0h r=%0h dz=%b",
                   e.name, bus.q, bus.r, bus.dz, e.q, e.r, e.dz);
        end else begin
          $display("done %s q=%0h r=%0h dz=%b", e.name, bus.q, bus.r, bus.dz);
        end
      end
    end
  end

  task automatic push(input string name, input logic [31:0] q, input logic [31:0] r, input logic dz);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.name = name;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    lat_cnt   = 0;
    busy_cyc  = 0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    while (!bus.done && lat_cnt < 200) tick();
    check({name, "_lat"}, 32'(lat_cnt), 32'(exp_lat));
    check({name, "_busy"}, 32'(busy_cyc), 32'(exp_busy));
  endtask

  function automatic int lat_for(input logic [31:0] b);
`ifdef DIVU_ZERO_FAST_EN
    if (b == 0) return 1;
`endif
    return 33;
  endfunction

  initial begin
    int nd0;
    logic [31:0] ra, rb, rq, rr;
    n_cmp = 0; n_bad = 0; n_done = 0; lat_cnt = 0; busy_cyc = 0;
    reset = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) tick();
    check("rst_q", bus.q, 0);
    check("rst_r", bus.r, 0);
    check("rst_flags", {29'd0, bus.busy, bus.done, bus.dz}, 0);
    reset = 1'b0;
    tick();

    // 1: basic divide, latency and hold
    push("t1_100_7", 32'd14, 32'd2, 1'b0);
    issue(32'd100, 32'd7);
    wait_done("t1", 33, 32);
    tick();
    check("t1_hold_q", bus.q, 32'd14);
    check("t1_done_low", {31'd0, bus.done}, 0);

    // 2: boundary vectors
    push("t2_max_1", 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(32'hFFFF_FFFF, 32'd1); wait_done("t2a", 33, 32); tick();
    push("t2_5_max", 32'd0, 32'd5, 1'b0);
    issue(32'd5, 32'hFFFF_FFFF); wait_done("t2b", 33, 32); tick();
    push("t2_a_eq_b", 32'd1, 32'd0, 1'b0);
    issue(32'd7, 32'd7); wait_done("t2c", 33, 32); tick();
    push("t2_a_zero", 32'd0, 32'd0, 1'b0);
    issue(32'd0, 32'd9); wait_done("t2d", 33, 32); tick();
    push("t2_a_lt_b", 32'd0, 32'd3, 1'b0);
    issue(32'd3, 32'd10); wait_done("t2e", 33, 32); tick();

    // 3: divide by zero
    push("t3_div0", 32'hFFFF_FFFF, 32'd1234, 1'b1);
    issue(32'd1234, 32'd0);
    wait_done("t3", lat_for(32'd0), lat_for(32'd0) - 1);
    tick();
    check("t3_hold_dz", {31'd0, bus.dz}, 1);

    // 4: start while busy is ignored, operands changed after acceptance
    push("t4_50_5", 32'd10, 32'd0, 1'b0);
    issue(32'd50, 32'd5);
    repeat (9) tick();
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd3;
    tick();
    bus.start = 1'b0; bus.a = 32'd1; bus.b = 32'd1;
    wait_done("t4", 33, 32);
    tick();

    // 5: reset mid-operation
    issue(32'd77, 32'd3);
    repeat (11) tick();
    reset = 1'b1;
    #1;
    check("t5_rst_q", bus.q, 0);
    check("t5_rst_r", bus.r, 0);
    check("t5_rst_flags", {29'd0, bus.busy, bus.done, bus.dz}, 0);
    nd0 = n_done;
    tick(); tick();
    reset = 1'b0;
    repeat (40) tick();
    check("t5_no_done", 32'(n_done), 32'(nd0));
    push("t5_77_3", 32'd25, 32'd2, 1'b0);
    issue(32'd77, 32'd3);
    wait_done("t5", 33, 32);
    tick();

    // 6: start held through DONE gives back-to-back operations
    push("t6_20_6", 32'd3, 32'd2, 1'b0);
    push("t6_21_4", 32'd5, 32'd1, 1'b0);
    bus.start = 1'b1; bus.a = 32'd20; bus.b = 32'd6;
    lat_cnt = 0; busy_cyc = 0;
    tick();
    bus.a = 32'd21; bus.b = 32'd4;
    wait_done("t6a", 33, 32);
    lat_cnt = 0; busy_cyc = 0;
    tick();
    bus.start = 1'b0;
    check("t6_b2b_busy", {31'd0, bus.busy}, 1);
    wait_done("t6b", 33, 32);
    tick();

    // random sweep against a reference quotient/remainder
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (rb == 0) begin rq = 32'hFFFF_FFFF; rr = ra; end
      else begin rq = ra / rb; rr = ra % rb; end
      push($sformatf("rnd%0d", i), rq, rr, rb == 0);
      issue(ra, rb);
      wait_done("rnd", lat_for(rb), lat_for(rb) - 1);
      tick();
    end

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
